// File: rtl/mcycle_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : mcycle_mac_unit
// Description : Multi-cycle multiply-accumulate responder on the MCycle
//               Start/Busy handshake. Optional saturation via MAC_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mcycle_mac_unit #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    localparam int              ACC_W  = 2 * WIDTH;
    localparam int              CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [1:0]      OP_SMLA  = 2'b00;
    localparam logic [1:0]      OP_UMLA  = 2'b01;
    localparam logic [1:0]      OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [1:0]         op_q,     op_d;
    logic [ACC_W-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [ACC_W-1:0]   prod_q,   prod_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic [ACC_W-1:0]   sum_w;

`ifdef MAC_SAT_EN
    logic               carry_w;
    logic               ovf_s_w;
    always_comb begin
        {carry_w, sum_w} = {1'b0, acc_q} + {1'b0, prod_q};
        // Signed overflow: both addends share a sign that the sum lost.
        ovf_s_w = (acc_q[ACC_W-1] == prod_q[ACC_W-1]) &&
                  (sum_w[ACC_W-1] != acc_q[ACC_W-1]);
        if (op_q == OP_SMLA && ovf_s_w) begin
            sum_w = prod_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
        end else if (op_q == OP_UMLA && carry_w) begin
            sum_w = {ACC_W{1'b1}};
        end
    end
`else
    always_comb begin
        sum_w = acc_q + prod_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    op_d     = MCycleOp;
                    mcand_d  = MCycleOp[0] ? {{WIDTH{1'b0}}, Operand1}
                                           : {{WIDTH{Operand1[WIDTH-1]}}, Operand1};
                    mplier_d = Operand2;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = MCycleOp[1] ? ST_FINISH : ST_MULT;
                end
            end
            ST_MULT: begin
                // The signed multiplier's top bit carries negative weight.
                if (mplier_q[0]) begin
                    if (op_q == OP_SMLA && cnt_q == C_LAST)
                        prod_d = prod_q - mcand_q;
                    else
                        prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == C_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_FINISH: begin
                if (op_q == OP_CLEAR)
                    acc_d = '0;
                else if (!op_q[1])
                    acc_d = sum_w;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
        end
    end

    // The accumulator only changes in FINISH, so it doubles as the result.
    assign Result1 = acc_q[WIDTH-1:0];
    assign Result2 = acc_q[ACC_W-1:WIDTH];
    assign Busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mcycle_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcycle_mac_unit
// Description : Scoreboard bench for mcycle_mac_unit against an arithmetic
//               reference model (honours MAC_SAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcycle_mac_unit;

    localparam int W  = 4;
    localparam int AW = 2 * W;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          Start;
    logic [1:0]    MCycleOp;
    logic [W-1:0]  Operand1, Operand2;
    logic [W-1:0]  Result1, Result2;
    logic          Busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] acc_m;
    logic [AW-1:0] exp_res_q[$];
    int            exp_lat_q[$];

    mcycle_mac_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the whole accumulator.
    task automatic push_exp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint s;
        longint maxs = (longint'(1) << (AW - 1)) - 1;
        longint mins = -(longint'(1) << (AW - 1));
        longint maxu = (longint'(1) << AW) - 1;
        case (op)
            2'b00: begin
                s = longint'($signed(acc_m)) + longint'($signed(a)) * longint'($signed(b));
`ifdef MAC_SAT_EN
                if (s > maxs) s = maxs;
                if (s < mins) s = mins;
`endif
                acc_m = s[AW-1:0];
            end
            2'b01: begin
                s = longint'(acc_m) + longint'(a) * longint'(b);
`ifdef MAC_SAT_EN
                if (s > maxu) s = maxu;
`endif
                acc_m = s[AW-1:0];
            end
            2'b10: acc_m = '0;
            default: ;
        endcase
        exp_res_q.push_back(acc_m);
        exp_lat_q.push_back(op[1] ? 1 : W + 1);
    endtask

    // Monitor: pops the scoreboard on every completed (Busy falling) op.
    initial begin : monitor
        int   busy_cnt = 0;
        logic prev_busy = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                busy_cnt  = 0;
                prev_busy = 1'b0;
            end else begin
                if (Busy) begin
                    busy_cnt++;
                end else if (prev_busy) begin
                    if (exp_res_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        check("sb_result", {Result2, Result1}, exp_res_q.pop_front());
                        check("sb_busy_len", busy_cnt, exp_lat_q.pop_front());
                    end
                    busy_cnt = 0;
                end
                prev_busy = Busy;
            end
        end
    end

    task automatic wait_busy(input logic v, input string name);
        for (int t = 0; t < 64; t++) begin
            if (Busy == v) return;
            @(negedge CLK);
        end
        check(name, Busy, v);
    endtask

    // Issue one op from idle; scramble all inputs while Busy.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
        push_exp(op, a, b);
        @(negedge CLK);
        for (int t = 0; t < 64; t++) begin
            if (!Busy) break;
            Start    = 1'($urandom_range(0, 1));
            MCycleOp = 2'($urandom_range(0, 3));
            Operand1 = W'($urandom);
            Operand2 = W'($urandom);
            @(negedge CLK);
        end
        Start = 1'b0;
        if (Busy) check("op_timeout", Busy, 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = '0; Operand2 = '0;
        acc_m = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check("reset_busy", Busy, 0);
        check("reset_result", {Result2, Result1}, 0);

        do_op(2'b10, 4'h3, 4'h5);
        check("clear_result", {Result2, Result1}, 8'h00);

        do_op(2'b01, 4'hF, 4'hF);
        check("umla_15x15", {Result2, Result1}, 8'hE1);
        do_op(2'b01, 4'hF, 4'hF);
`ifdef MAC_SAT_EN
        check("umla_sat", {Result2, Result1}, 8'hFF);
`else
        check("umla_wrap", {Result2, Result1}, 8'hC2);
`endif

        do_op(2'b10, 4'h0, 4'h0);
        do_op(2'b00, 4'hD, 4'h2);
        check("smla_m3x2", {Result2, Result1}, 8'hFA);
        do_op(2'b00, 4'h8, 4'h7);
        check("smla_m8x7", {Result2, Result1}, 8'hC2);

        do_op(2'b10, 4'h0, 4'h0);
        do_op(2'b00, 4'h8, 4'h8);
        check("smla_m8xm8", {Result2, Result1}, 8'h40);
        do_op(2'b00, 4'h8, 4'h8);
`ifdef MAC_SAT_EN
        check("smla_sat", {Result2, Result1}, 8'h7F);
`else
        check("smla_wrap", {Result2, Result1}, 8'h80);
`endif

        // Start held high: back-to-back -1 x -1 accumulations.
        do_op(2'b10, 4'h0, 4'h0);
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 4'hF; Operand2 = 4'hF;
        push_exp(2'b00, 4'hF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            wait_busy(1'b1, "b2b_rise_timeout");
            repeat (W - 2) begin
                MCycleOp = 2'($urandom_range(0, 3));
                Operand1 = W'($urandom);
                Operand2 = W'($urandom);
                @(negedge CLK);
            end
            MCycleOp = 2'b00; Operand1 = 4'hF; Operand2 = 4'hF;
            wait_busy(1'b0, "b2b_fall_timeout");
            check("b2b_result", {Result2, Result1}, k + 1);
            if (k < 2) begin
                push_exp(2'b00, 4'hF, 4'hF);
                @(negedge CLK);
                check("b2b_gap_one_cycle", Busy, 1);
            end else begin
                Start = 1'b0;
            end
        end
        @(negedge CLK);

        // Reset on the third Busy cycle of an MLA discards it.
        Start = 1'b1; MCycleOp = 2'b00; Operand1 = 4'h5; Operand2 = 4'h3;
        @(negedge CLK);
        Start = 1'b0;
        check("pre_reset_busy", Busy, 1);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        acc_m = '0;
        check("midop_reset_busy", Busy, 0);
        check("midop_reset_result", {Result2, Result1}, 0);
        do_op(2'b11, 4'h9, 4'h9);
        check("read_after_reset", {Result2, Result1}, 8'h00);

        // Randomized ops with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            do_op(2'($urandom_range(0, 3)), W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        // Results must hold while idle.
        repeat (5) @(negedge CLK);
        check("idle_hold", {Result2, Result1}, acc_m);
        check("sb_drained", exp_res_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
